// File: rtl/bittiming_seq.sv
`default_nettype none
// ============================================================================
// Module   : bittiming_seq
// Purpose  : CAN bit-timing sequencer (sync/phase-1/phase-2, hard sync, SJW resync)
// Revision : 1.0
// ============================================================================
module bittiming_seq (
  input  logic       clock,
  input  logic       reset,
  input  logic       prescale_en,
  input  logic       rx,
  input  logic [2:0] tseg1,
  input  logic [2:0] tseg2,
  input  logic [1:0] sjw,
  input  logic       hardsync_en,
  input  logic       resync_en,
  input  logic [4:0] tseg1mpl,
  output logic [1:0] ctrl,
  output logic [4:0] tseg1pcount,
  output logic [4:0] tseg1p1psjw,
  output logic       sample,
  output logic       smpledbit,
  output logic       sendpoint,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    ST_SYNC   = 2'b00,
    ST_PHASE1 = 2'b01,
    ST_PHASE2 = 2'b10
  } state_t;

  localparam logic [1:0] c_ctrl_hold   = 2'b00;
  localparam logic [1:0] c_ctrl_tseg1  = 2'b01;
  localparam logic [1:0] c_ctrl_pcount = 2'b10;
  localparam logic [1:0] c_ctrl_psjw   = 2'b11;

  state_t     r_state,       w_state_nxt;
  logic [4:0] r_count,       w_count_nxt;
  logic [1:0] r_ctrl,        w_ctrl_nxt;
  logic [4:0] r_pcount,      w_pcount_nxt;
  logic [4:0] r_psjw,        w_psjw_nxt;
  logic       r_sample,      w_sample_nxt;
  logic       r_smpledbit,   w_smpledbit_nxt;
  logic       r_sendpoint,   w_sendpoint_nxt;
  logic       r_rx_tq,       w_rx_tq_nxt;
  logic       r_rsync_done,  w_rsync_done_nxt;
  logic [2:0] r_p2lim,       w_p2lim_nxt;

  logic       w_edge;
  logic       w_resync;
  logic [4:0] w_sjw_p1;
  logic [4:0] w_p2_remain;

  assign w_edge      = prescale_en & r_rx_tq & ~rx;
  assign w_resync    = w_edge & resync_en & ~r_rsync_done;
  assign w_sjw_p1    = {3'b000, sjw} + 5'd1;
  // Count never exceeds p2lim while in PHASE2, so this cannot wrap.
  assign w_p2_remain = {2'b00, r_p2lim} - r_count;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state      <= ST_SYNC;
      r_count      <= 5'd0;
      r_ctrl       <= c_ctrl_hold;
      r_pcount     <= 5'd0;
      r_psjw       <= 5'd0;
      r_sample     <= 1'b0;
      r_smpledbit  <= 1'b1;
      r_sendpoint  <= 1'b0;
      r_rx_tq      <= 1'b1;
      r_rsync_done <= 1'b0;
      r_p2lim      <= 3'd0;
    end else begin
      r_state      <= w_state_nxt;
      r_count      <= w_count_nxt;
      r_ctrl       <= w_ctrl_nxt;
      r_pcount     <= w_pcount_nxt;
      r_psjw       <= w_psjw_nxt;
      r_sample     <= w_sample_nxt;
      r_smpledbit  <= w_smpledbit_nxt;
      r_sendpoint  <= w_sendpoint_nxt;
      r_rx_tq      <= w_rx_tq_nxt;
      r_rsync_done <= w_rsync_done_nxt;
      r_p2lim      <= w_p2lim_nxt;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_count_nxt      = r_count;
    w_ctrl_nxt       = c_ctrl_hold;
    w_pcount_nxt     = r_pcount;
    w_psjw_nxt       = r_psjw;
    w_sample_nxt     = 1'b0;
    w_smpledbit_nxt  = r_smpledbit;
    w_sendpoint_nxt  = 1'b0;
    w_rx_tq_nxt      = r_rx_tq;
    w_rsync_done_nxt = r_rsync_done;
    w_p2lim_nxt      = r_p2lim;

    if (prescale_en) begin
      w_rx_tq_nxt = rx;
      if (w_edge && hardsync_en) begin
        // The edge tq itself is the sync segment.
        w_state_nxt      = ST_PHASE1;
        w_count_nxt      = 5'd0;
        w_ctrl_nxt       = c_ctrl_tseg1;
        w_sendpoint_nxt  = 1'b1;
        w_rsync_done_nxt = 1'b1;
      end else begin
        case (r_state)
          ST_SYNC: begin
            w_sendpoint_nxt  = 1'b1;
            w_ctrl_nxt       = c_ctrl_tseg1;
            w_state_nxt      = ST_PHASE1;
            w_count_nxt      = 5'd0;
            w_rsync_done_nxt = 1'b0;
          end
          ST_PHASE1: begin
            if (w_resync) begin
              // Late edge: lengthen phase-1 by the error, clipped to SJW.
              w_pcount_nxt     = {2'b00, tseg1} + r_count + 5'd1;
              w_psjw_nxt       = {2'b00, tseg1} + w_sjw_p1;
              w_ctrl_nxt       = (r_count <= {3'b000, sjw}) ? c_ctrl_pcount : c_ctrl_psjw;
              w_rsync_done_nxt = 1'b1;
              w_count_nxt      = r_count + 5'd1;
            end else if (r_count == tseg1mpl) begin
              w_sample_nxt     = 1'b1;
              w_smpledbit_nxt  = rx;
              w_state_nxt      = ST_PHASE2;
              w_count_nxt      = 5'd0;
              w_p2lim_nxt      = tseg2;
              w_rsync_done_nxt = 1'b0;
            end else begin
              w_count_nxt = r_count + 5'd1;
            end
          end
          ST_PHASE2: begin
            if (w_resync) begin
              w_rsync_done_nxt = 1'b1;
              if (w_p2_remain <= w_sjw_p1) begin
                w_state_nxt     = ST_PHASE1;
                w_count_nxt     = 5'd0;
                w_ctrl_nxt      = c_ctrl_tseg1;
                w_sendpoint_nxt = 1'b1;
              end else begin
                w_p2lim_nxt = r_p2lim - {1'b0, sjw} - 3'd1;
                w_count_nxt = r_count + 5'd1;
              end
            end else if (r_count == {2'b00, r_p2lim}) begin
              w_state_nxt = ST_SYNC;
              w_count_nxt = 5'd0;
            end else begin
              w_count_nxt = r_count + 5'd1;
            end
          end
          default: begin
            w_state_nxt = ST_SYNC;
            w_count_nxt = 5'd0;
          end
        endcase
      end
    end
  end

  assign ctrl        = r_ctrl;
  assign tseg1pcount = r_pcount;
  assign tseg1p1psjw = r_psjw;
  assign sample      = r_sample;
  assign smpledbit   = r_smpledbit;
  assign sendpoint   = r_sendpoint;
  assign state       = r_state;

endmodule
`default_nettype wire

// File: tb/tb_bittiming_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_bittiming_seq
// Purpose  : scoreboard bench for bittiming_seq with a model of the tseg register
// Revision : 1.0
// ============================================================================
module tb_bittiming_seq;

  logic       clock = 1'b0;
  logic       reset;
  logic       prescale_en;
  logic       rx;
  logic [2:0] tseg1;
  logic [2:0] tseg2;
  logic [1:0] sjw;
  logic       hardsync_en;
  logic       resync_en;
  logic [4:0] tseg1mpl;
  logic [1:0] ctrl;
  logic [4:0] tseg1pcount;
  logic [4:0] tseg1p1psjw;
  logic       sample;
  logic       smpledbit;
  logic       sendpoint;
  logic [1:0] state;

  always #5 clock = ~clock;

  bittiming_seq dut (
    .clock       (clock),
    .reset       (reset),
    .prescale_en (prescale_en),
    .rx          (rx),
    .tseg1       (tseg1),
    .tseg2       (tseg2),
    .sjw         (sjw),
    .hardsync_en (hardsync_en),
    .resync_en   (resync_en),
    .tseg1mpl    (tseg1mpl),
    .ctrl        (ctrl),
    .tseg1pcount (tseg1pcount),
    .tseg1p1psjw (tseg1p1psjw),
    .sample      (sample),
    .smpledbit   (smpledbit),
    .sendpoint   (sendpoint),
    .state       (state)
  );

  // Phase-1 length register driven by ctrl, one clock of latency.
  always @(posedge clock or posedge reset) begin
    if (reset) tseg1mpl <= 5'd0;
    else begin
      case (ctrl)
        2'b01:   tseg1mpl <= {2'b00, tseg1};
        2'b10:   tseg1mpl <= tseg1pcount;
        2'b11:   tseg1mpl <= tseg1p1psjw;
        default: tseg1mpl <= tseg1mpl;
      endcase
    end
  end

  typedef struct packed {
    logic [31:0] tick;
    logic        sp;
    logic        smp;
    logic        sbit;
    logic [1:0]  c;
    logic [4:0]  pc;
    logic [4:0]  ps;
  } ev_t;

  ev_t exp_q[$];
  int  n_vec   = 0;
  int  n_bad   = 0;
  int  tick_no = 0;

  task automatic push(input int t, input logic sp, input logic smp, input logic sbit,
                      input logic [1:0] c, input logic [4:0] pc, input logic [4:0] ps);
    ev_t e;
    e.tick = 32'(t);
    e.sp   = sp;
    e.smp  = smp;
    e.sbit = sbit;
    e.c    = c;
    e.pc   = pc;
    e.ps   = ps;
    exp_q.push_back(e);
  endtask

  task automatic chk(input string name, input int act, input int expv);
    n_vec++;
    if (act != expv) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, expv);
    end
  endtask

  // Monitor: every output pulse or ctrl command is matched against the queue.
  always @(negedge clock) begin
    if (!reset && (sample || sendpoint || ctrl != 2'b00)) begin
      ev_t e;
      logic ok;
      n_vec++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_event tick=%0d: sp=%b sample=%b ctrl=%b, expected no event",
                 tick_no, sendpoint, sample, ctrl);
      end else begin
        e  = exp_q.pop_front();
        ok = (32'(tick_no) == e.tick) && (sendpoint == e.sp) && (sample == e.smp) &&
             (ctrl == e.c) && (!e.smp || smpledbit == e.sbit) &&
             (!e.c[1] || (tseg1pcount == e.pc && tseg1p1psjw == e.ps));
        if (!ok) begin
          n_bad++;
          $display("FAIL event: got tick=%0d sp=%b smp=%b bit=%b ctrl=%b pc=%0d ps=%0d, expected tick=%0d sp=%b smp=%b bit=%b ctrl=%b pc=%0d ps=%0d",
                   tick_no, sendpoint, sample, smpledbit, ctrl, tseg1pcount, tseg1p1psjw,
                   e.tick, e.sp, e.smp, e.sbit, e.c, e.pc, e.ps);
        end
      end
    end
  end

  // One tq: tick on this clock, then three idle clocks.
  task automatic tick(input logic r);
    rx          = r;
    prescale_en = 1'b1;
    tick_no++;
    @(negedge clock);
    prescale_en = 1'b0;
    repeat (3) @(negedge clock);
  endtask

  // rxb[i] is the bus level at tick S+i; hardsync_en is raised only at tick S+hs_at.
  task automatic run(input int n, input logic [31:0] rxb, input int hs_at);
    for (int i = 0; i < n; i++) begin
      hardsync_en = (i == hs_at);
      tick(rxb[i]);
    end
    hardsync_en = 1'b0;
  endtask

  task automatic nominal_bit();
    int s;
    s = tick_no + 1;
    push(s,     1'b1, 1'b0, 1'b0, 2'b01, 5'd0, 5'd0);
    push(s + 4, 1'b0, 1'b1, 1'b1, 2'b00, 5'd0, 5'd0);
    run(8, 32'hFFFF_FFFF, -1);
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_state"},     int'(state),       0);
    chk({tag, "_ctrl"},      int'(ctrl),        0);
    chk({tag, "_smpledbit"}, int'(smpledbit),   1);
    chk({tag, "_sample"},    int'(sample),      0);
    chk({tag, "_sendpoint"}, int'(sendpoint),   0);
    chk({tag, "_pcount"},    int'(tseg1pcount), 0);
    chk({tag, "_psjw"},      int'(tseg1p1psjw), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int s;
    reset       = 1'b1;
    prescale_en = 1'b0;
    rx          = 1'b1;
    tseg1       = 3'd3;
    tseg2       = 3'd2;
    sjw         = 2'd1;
    hardsync_en = 1'b0;
    resync_en   = 1'b1;
    repeat (3) @(negedge clock);
    check_reset_state("por");
    reset = 1'b0;
    @(negedge clock);

    // One full bit, then stop in PHASE2 and reset mid-bit.
    nominal_bit();
    s = tick_no + 1;
    push(s,     1'b1, 1'b0, 1'b0, 2'b01, 5'd0, 5'd0);
    push(s + 4, 1'b0, 1'b1, 1'b1, 2'b00, 5'd0, 5'd0);
    run(6, 32'hFFFF_FFFF, -1);
    chk("state_mid_phase2", int'(state), 2);
    reset = 1'b1;
    @(negedge clock);
    check_reset_state("midbit");
    reset = 1'b0;
    @(negedge clock);

    nominal_bit();
    nominal_bit();

    // Late edge at PHASE1 c=1: phase error 2 within SJW.
    s = tick_no + 1;
    push(s,     1'b1, 1'b0, 1'b0, 2'b01, 5'd0, 5'd0);
    push(s + 2, 1'b0, 1'b0, 1'b0, 2'b10, 5'd5, 5'd5);
    push(s + 6, 1'b0, 1'b1, 1'b0, 2'b00, 5'd0, 5'd0);
    run(10, 32'h0000_0383, -1);

    // Late edge at PHASE1 c=3, on the sample point: clipped to SJW.
    s = tick_no + 1;
    push(s,     1'b1, 1'b0, 1'b0, 2'b01, 5'd0, 5'd0);
    push(s + 4, 1'b0, 1'b0, 1'b0, 2'b11, 5'd7, 5'd5);
    push(s + 6, 1'b0, 1'b1, 1'b0, 2'b00, 5'd0, 5'd0);
    run(10, 32'h0000_038F, -1);

    // Early edge at PHASE2 c=1 with tseg2=2: bit ends immediately.
    s = tick_no + 1;
    push(s,      1'b1, 1'b0, 1'b0, 2'b01, 5'd0, 5'd0);
    push(s + 4,  1'b0, 1'b1, 1'b1, 2'b00, 5'd0, 5'd0);
    push(s + 6,  1'b1, 1'b0, 1'b0, 2'b01, 5'd0, 5'd0);
    push(s + 10, 1'b0, 1'b1, 1'b0, 2'b00, 5'd0, 5'd0);
    run(14, 32'h0000_383F, -1);

    // Early edge at PHASE2 c=1 with tseg2=6: phase-2 shrinks by 2 tq.
    tseg2 = 3'd6;
    s = tick_no + 1;
    push(s,     1'b1, 1'b0, 1'b0, 2'b01, 5'd0, 5'd0);
    push(s + 4, 1'b0, 1'b1, 1'b1, 2'b00, 5'd0, 5'd0);
    run(10, 32'h0000_003F, -1);
    tseg2 = 3'd2;

    // Hard sync at PHASE2 c=0, then a second edge that must not resync.
    s = tick_no + 1;
    push(s,     1'b1, 1'b0, 1'b0, 2'b01, 5'd0, 5'd0);
    push(s + 4, 1'b0, 1'b1, 1'b1, 2'b00, 5'd0, 5'd0);
    push(s + 5, 1'b1, 1'b0, 1'b0, 2'b01, 5'd0, 5'd0);
    push(s + 9, 1'b0, 1'b1, 1'b0, 2'b00, 5'd0, 5'd0);
    run(13, 32'h0000_1C5F, 5);

    nominal_bit();
    s = tick_no + 1;
    push(s, 1'b1, 1'b0, 1'b0, 2'b01, 5'd0, 5'd0);
    tick(1'b1);
    repeat (2) @(negedge clock);
    chk("queue_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
